dmem_mmio: RTL and testbench

//   Data-side memory subsystem driven by the CPU MEM-stage port (mem_w, DMType_out, Addr_out, Data_out).

---
 rtl/dmem_mmio.sv | 100 ++++++++++
 tb/tb_dmem_mmio.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side RAM with sub-word load/store plus a GPIO and compare-timer MMIO window.
module dmem_mmio #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          GPIO_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_w,
    input  logic [2:0]        dm_type,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              misalign_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0]       r_mem [DEPTH_WORDS];
    logic [GPIO_W-1:0] r_gpio_out, r_sync1, r_sync2;
    logic [31:0]       r_tcount, r_tcmp;
    logic              r_en, r_ar, r_pend, r_err;
    logic              w_mmio, w_ram, w_half, w_byte, w_mis, w_ram_we, w_mmio_we, w_match;
    logic [AW-1:0]     w_idx;
    logic [11:0]       w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wd, w_rw, w_ram_rd, w_mmio_rd;
    logic [15:0]       w_h;
    logic [7:0]        w_b;
    assign w_mmio = addr[31:12] == MMIO_BASE[31:12];
    assign w_ram  = !w_mmio && ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_half = dm_type == 3'b001 || dm_type == 3'b010;
    assign w_byte = dm_type == 3'b011 || dm_type == 3'b100;
    // MMIO registers accept only aligned word accesses; anything else is treated as misaligned
    assign w_mis  = w_mmio ? (addr[1:0] != 2'b00 || dm_type != 3'b000)
                  : w_half ? addr[0]
                  : w_byte ? 1'b0
                  : addr[1:0] != 2'b00;
    assign w_idx     = addr[AW+1:2];
    assign w_off     = addr[11:0];
    assign w_ram_we  = mem_w && !reset && w_ram && !w_mis;
    assign w_mmio_we = mem_w && w_mmio && !w_mis;
    assign w_match   = r_en && r_tcount == r_tcmp;
    assign w_be = w_half ? (addr[1] ? 4'b1100 : 4'b0011)
                : w_byte ? 4'b0001 << addr[1:0]
                : 4'b1111;
    assign w_wd = w_half ? {2{wdata[15:0]}} : w_byte ? {4{wdata[7:0]}} : wdata;
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (w_ram_we && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
    end
    assign w_rw = r_mem[w_idx];
    assign w_b  = w_rw[{addr[1:0], 3'b000} +: 8];
    assign w_h  = addr[1] ? w_rw[31:16] : w_rw[15:0];
    assign w_ram_rd = dm_type == 3'b001 ? {{16{w_h[15]}}, w_h}
                    : dm_type == 3'b010 ? {16'h0000, w_h}
                    : dm_type == 3'b011 ? {{24{w_b[7]}}, w_b}
                    : dm_type == 3'b100 ? {24'h000000, w_b}
                    : w_rw;
    assign w_mmio_rd = w_off == 12'h000 ? 32'(r_gpio_out)
                     : w_off == 12'h004 ? 32'(r_sync2)
                     : w_off == 12'h008 ? r_tcount
                     : w_off == 12'h00C ? r_tcmp
                     : w_off == 12'h010 ? {29'd0, r_pend, r_ar, r_en}
                     : 32'd0;
    assign rdata = w_mis ? 32'd0 : w_mmio ? w_mmio_rd : w_ram ? w_ram_rd : 32'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tcount   <= '0;
            r_tcmp     <= '0;
            r_en       <= 1'b0;
            r_ar       <= 1'b0;
            r_pend     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_err   <= w_mis;
            if (w_mmio_we && w_off == 12'h000) r_gpio_out <= wdata[GPIO_W-1:0];
            if (w_mmio_we && w_off == 12'h00C) r_tcmp <= wdata;
            // CPU store to TCOUNT wins over the timer's own increment/reload
            if (w_mmio_we && w_off == 12'h008) r_tcount <= wdata;
            else if (r_en) r_tcount <= (w_match && r_ar) ? 32'd0 : r_tcount + 32'd1;
            if (w_mmio_we && w_off == 12'h010) begin
                r_en <= wdata[0];
                r_ar <= wdata[1];
            end
            // a match in the same cycle beats the W1C clear
            if (w_match) r_pend <= 1'b1;
            else if (w_mmio_we && w_off == 12'h010 && wdata[2]) r_pend <= 1'b0;
        end
    end
    assign gpio_out     = r_gpio_out;
    assign timer_irq    = r_pend;
    assign misalign_err = r_err;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed checks of RAM sub-word access, alignment errors, GPIO and compare timer.
module tb_dmem_mmio;
    localparam logic [2:0] W = 3'b000, H = 3'b001, HU = 3'b010, B = 3'b011, BU = 3'b100;
    localparam logic [31:0] GOUT = 32'hFFFF_0000, GIN = 32'hFFFF_0004, TCNT = 32'hFFFF_0008,
                            TCMP = 32'hFFFF_000C, TCTL = 32'hFFFF_0010;
    logic        clk = 1'b0, reset = 1'b1, mem_w = 1'b0;
    logic [2:0]  dm_type = 3'b000;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [15:0] gpio_in = '0, gpio_out;
    logic        timer_irq, misalign_err;
    int          checks = 0, errors = 0;

    dmem_mmio dut (
        .clk(clk), .reset(reset), .mem_w(mem_w), .dm_type(dm_type), .addr(addr),
        .wdata(wdata), .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .timer_irq(timer_irq), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // one bus cycle: inputs change on the falling edge, outputs sampled 1 time unit later
    task automatic cyc(input logic rst, input logic mw, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] t);
        @(negedge clk);
        reset = rst; mem_w = mw; addr = a; wdata = d; dm_type = t;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, W);
        cyc(1, 0, 0, 0, W);
        cyc(0, 0, TCNT, 0, W);
        chk("rst_gpio_out", 32'(gpio_out), 0);
        chk("rst_irq", 32'(timer_irq), 0);
        chk("rst_err", 32'(misalign_err), 0);
        chk("rst_tcount", rdata, 0);
        cyc(0, 0, TCTL, 0, W);
        chk("rst_tctrl", rdata, 0);
        // RAM word/sub-word loads
        cyc(0, 1, 32'h0, 32'hCAFEF00D, W);
        cyc(0, 1, 32'h10, 32'h8899AABB, W);
        cyc(0, 0, 32'h11, 0, B);
        chk("lb_11", rdata, 32'hFFFFFFAA);
        cyc(0, 0, 32'h13, 0, BU);
        chk("lbu_13", rdata, 32'h00000088);
        cyc(0, 0, 32'h12, 0, H);
        chk("lh_12", rdata, 32'hFFFF8899);
        cyc(0, 0, 32'h10, 0, HU);
        chk("lhu_10", rdata, 32'h0000AABB);
        cyc(0, 0, 32'h10, 0, W);
        chk("lw_10", rdata, 32'h8899AABB);
        // store merging with read-during-write showing old data
        cyc(0, 1, 32'h12, 32'hFFFFFF55, B);
        chk("sb_rdw", rdata, 32'hFFFFFF99);
        cyc(0, 0, 32'h10, 0, W);
        chk("sb_merge", rdata, 32'h8855AABB);
        cyc(0, 1, 32'h10, 32'h00001234, H);
        chk("sh_rdw", rdata, 32'hFFFFAABB);
        cyc(0, 0, 32'h10, 0, W);
        chk("sh_merge", rdata, 32'h88551234);
        // misaligned store and load
        cyc(0, 1, 32'h11, 32'h0000FFFF, H);
        chk("mis_st_rd", rdata, 0);
        chk("mis_err_pre", 32'(misalign_err), 0);
        cyc(0, 0, 32'h10, 0, W);
        chk("mis_st_word", rdata, 32'h88551234);
        chk("mis_err_pulse", 32'(misalign_err), 1);
        cyc(0, 0, 32'h02, 0, W);
        chk("mis_err_clear", 32'(misalign_err), 0);
        chk("mis_lw_rd", rdata, 0);
        cyc(0, 0, 32'h13, 0, B);
        chk("mis_ld_err", 32'(misalign_err), 1);
        chk("lb_13", rdata, 32'hFFFFFF88);
        cyc(0, 0, 32'h13, 0, B);
        chk("byte_no_err", 32'(misalign_err), 0);
        // unmapped region and top RAM word
        cyc(0, 1, 32'h1000, 32'hDEADBEEF, W);
        cyc(0, 0, 32'h1000, 0, W);
        chk("unmapped_rd", rdata, 0);
        cyc(0, 0, 32'h0, 0, W);
        chk("unmapped_no_alias", rdata, 32'hCAFEF00D);
        cyc(0, 1, 32'hFFC, 32'h13579BDF, W);
        cyc(0, 0, 32'hFFC, 0, W);
        chk("top_word", rdata, 32'h13579BDF);
        // GPIO
        cyc(0, 1, GOUT, 32'hFFFFABCD, W);
        chk("gpio_rdw", 32'(gpio_out), 0);
        cyc(0, 0, GOUT, 0, W);
        chk("gpio_out", 32'(gpio_out), 32'h0000ABCD);
        chk("gpio_rd", rdata, 32'h0000ABCD);
        gpio_in = 16'h00F0;
        cyc(0, 0, GIN, 0, W);
        chk("gpio_in_1", rdata, 0);
        cyc(0, 1, GIN, 32'h1234, W);
        chk("gpio_in_2", rdata, 32'h000000F0);
        cyc(0, 0, GIN, 0, W);
        chk("gpio_in_ro", rdata, 32'h000000F0);
        cyc(0, 1, GOUT, 32'h11, B);
        cyc(0, 0, GOUT, 0, W);
        chk("mmio_sb_ignored", 32'(gpio_out), 32'h0000ABCD);
        chk("mmio_sb_err", 32'(misalign_err), 1);
        // timer with autoreload
        cyc(0, 1, TCMP, 3, W);
        cyc(0, 1, TCNT, 0, W);
        cyc(0, 1, TCTL, 3, W);
        cyc(0, 0, TCNT, 0, W);
        chk("t_c0", rdata, 0);
        cyc(0, 0, TCNT, 0, W);
        chk("t_c1", rdata, 1);
        cyc(0, 0, TCNT, 0, W);
        chk("t_c2", rdata, 2);
        cyc(0, 0, TCNT, 0, W);
        chk("t_c3", rdata, 3);
        chk("t_irq_pre", 32'(timer_irq), 0);
        cyc(0, 0, TCNT, 0, W);
        chk("t_reload", rdata, 0);
        chk("t_irq_rise", 32'(timer_irq), 1);
        cyc(0, 1, TCTL, 7, W);
        cyc(0, 0, TCNT, 0, W);
        chk("t_w1c_cnt", rdata, 2);
        chk("t_w1c_irq", 32'(timer_irq), 0);
        cyc(0, 1, TCTL, 7, W);
        cyc(0, 0, TCTL, 0, W);
        chk("t_w1c_match_irq", 32'(timer_irq), 1);
        chk("t_tctrl_rd", rdata, 7);
        cyc(0, 0, TCNT, 0, W);
        chk("t_after_w1c", rdata, 1);
        cyc(0, 1, TCNT, 32'h100, W);
        cyc(0, 0, TCNT, 0, W);
        chk("t_override", rdata, 32'h100);
        cyc(0, 1, TCNT, 32'hFFFFFFFE, W);
        cyc(0, 0, TCNT, 0, W);
        cyc(0, 0, TCNT, 0, W);
        chk("t_max", rdata, 32'hFFFFFFFF);
        cyc(0, 0, TCNT, 0, W);
        chk("t_wrap", rdata, 0);
        cyc(0, 1, TCTL, 0, W);
        cyc(0, 0, TCNT, 0, W);
        chk("t_en_old", rdata, 2);
        cyc(0, 0, TCNT, 0, W);
        chk("t_frozen", rdata, 2);
        chk("t_pend_kept", 32'(timer_irq), 1);
        cyc(0, 1, TCTL, 4, W);
        cyc(0, 0, TCNT, 0, W);
        chk("t_pend_clr", 32'(timer_irq), 0);
        // reset mid-count discards a same-cycle store
        cyc(0, 1, TCTL, 3, W);
        cyc(0, 0, TCNT, 0, W);
        cyc(0, 0, TCNT, 0, W);
        cyc(0, 0, TCNT, 0, W);
        chk("r_running", 32'(timer_irq), 1);
        cyc(1, 1, 32'h10, 32'h0, W);
        cyc(0, 0, TCNT, 0, W);
        chk("r_tcount", rdata, 0);
        chk("r_irq", 32'(timer_irq), 0);
        chk("r_gpio", 32'(gpio_out), 0);
        cyc(0, 0, TCTL, 0, W);
        chk("r_tctrl", rdata, 0);
        cyc(0, 0, TCNT, 0, W);
        chk("r_stopped", rdata, 0);
        cyc(0, 0, 32'h10, 0, W);
        chk("r_ram_kept", rdata, 32'h88551234);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
